sipo_deser: RTL
===============

# sipo_deser

Serial-in/parallel-out deserializer: the receive end of the team's bit-serial link, paired with the PISO serializer. It samples one bit per qualified clock, assembles WIDTH-bit words in the same bit order the serializer emits, and presents each completed word on a valid/ready output stage. It optionally checks word framing against the serializer's done pulse, and flags overrun when the consumer stalls.

## Interface
- WIDTH, default 8: word width in bits, must be ≥1.
- SHIFT_DIR, default 0: bit order. 0 = LSB first, so the first bit lands in data[0]. 1 = MSB first, so the first bit lands in data[WIDTH-1].
- CHECK_LAST, default 1: 1 enables framing checks on in_last; 0 ignores in_last.
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in, input, 1: serial data bit.
- in_valid, input, 1: the bit on `in` is sampled this cycle.
- in_last, input, 1: marks the final bit of a word, driven from the serializer's done output; qualified by in_valid.
- out_data, output, WIDTH: assembled word.
- out_valid, output, 1: out_data holds an unconsumed word.
- out_ready, input, 1: consumer accepts out_data.
- busy, output, 1: a partial word is in progress (bit_count ≠ 0).
- overrun, output, 1: one-cycle pulse, a completed word was dropped.
- frame_err, output, 1: one-cycle pulse, a framing violation occurred.

## Operation
- Shift register sreg holds WIDTH bits. bit_count width is max(1, clog2(WIDTH)) and runs 0..WIDTH-1.
- On an edge with in_valid=1:
  - Write `in` to sreg[bit_count] (SHIFT_DIR=0) or to sreg[WIDTH-1-bit_count] (SHIFT_DIR=1).
  - If bit_count = WIDTH-1, the word is complete: set bit_count to 0. Otherwise increment bit_count.
- in_valid=0: bit_count and sreg hold. Gaps of any length between bits are legal.
- Framing (CHECK_LAST=1):
  - in_last=1 with bit_count ≠ WIDTH-1: pulse frame_err, discard the partial word, set bit_count to 0. No word is emitted.
  - bit_count = WIDTH-1 with in_last=0: pulse frame_err, discard the word, set bit_count to 0.
  - in_last is ignored whenever in_valid=0.
- Output stage, evaluated at each edge:
  - Word completes and (out_valid=0 or out_ready=1): load out_data with the full word, including the bit sampled this edge, and set out_valid=1.
  - Word completes while out_valid=1 and out_ready=0: drop the new word, keep the old word, pulse overrun.
  - No completion and out_valid=1 and out_ready=1: clear out_valid. out_data holds its last value.
- WIDTH=1: every valid bit completes a word. busy stays 0. With CHECK_LAST=1, in_last must accompany every bit.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, overrun=0, frame_err=0, bit_count=0, sreg=0.
- Reset asserted mid-word or with out_valid=1 discards all state immediately.
- Latency: out_valid rises at the same edge that samples the last bit. A word's first sample edge to out_valid is WIDTH edges when there are no gaps.
- Throughput is one word per WIDTH valid bits. Back-to-back words with out_ready tied high never overrun.
- A completion coinciding with a handshake reloads out_data, and out_valid stays 1.
- frame_err and overrun are registered, high for exactly the cycle after the offending edge. They are not sticky.
- busy is registered from bit_count: high from the edge after the first bit through the edge that samples the last bit.

## Structure
- Shared package `sipo_pkg`:
  - Localparams LSB_FIRST=0 and MSB_FIRST=1, shared with the serializer.
  - Function `cnt_w(width)` returning max(1, clog2(width)).
- One sub-module, `sipo_out_stage`: the single-entry valid/ready holding register with overrun detection. Parameterized by WIDTH; inputs are the word, a load strobe, and out_ready.
- Top level contains the bit counter, shift register and framing check.

## Test plan
All scenarios use WIDTH=8.
1. SHIFT_DIR=0, out_ready=1, eight bits of 0xA5 sent LSB first with in_last on bit 7 -> out_valid for 1 cycle with out_data=0xA5, no error pulses.
2. SHIFT_DIR=1, same bit stream -> out_data=0xA5 bit-reversed (0xA5 reads as 1010_0101; the result is its MSB-first interpretation), checked against the serializer loopback at both SHIFT_DIR values with a random word.
3. in_valid gapped randomly (3 idle cycles between bits) -> bit_count holds across gaps, the word still assembles correctly, busy is high through the gaps.
4. out_ready=0, two consecutive words 0x11 then 0x22 -> out_data stays 0x11, a single overrun pulse appears, and 0x22 is lost. Raising out_ready then clears out_valid.
5. in_last asserted on bit 4 -> frame_err pulse, no out_valid, busy=0. The next 8 bits produce a correct word.
6. reset asserted after 5 bits -> all outputs are 0 immediately. The next full word assembles correctly from bit 0.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the bit-serial link (serializer and deserializer).
package sipo_pkg;

  // Bit-order selectors, identical in meaning on both ends of the link.
  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

  // Width of a counter that indexes a word of 'width' bits, at least one bit.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// Single-entry valid/ready holding register for assembled words.
// A word is offered on out_data while out_valid=1 and transfers at the
// edge where out_valid=1 and out_ready=1. out_data is not changed while
// out_valid=1 and out_ready=0. A load arriving while the entry is full and
// not being drained is dropped and reported as a one-cycle overrun pulse.
module sipo_out_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word,
  input  logic             load,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
);

  // Hold register: load on free/draining slot, drop-and-flag on full slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= load && out_valid && !out_ready;
      if (load && (!out_valid || out_ready)) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: bit counter, shift register and
// framing check feeding a single-entry valid/ready output stage.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SHIFT_DIR  = LSB_FIRST,
  parameter bit CHECK_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             in_last,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0]    bit_count;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] word;
  logic             at_last;
  logic             ferr;
  logic             complete;

  // Position the current bit lands in, according to the bit order.
  always_comb begin
    pos = (SHIFT_DIR == MSB_FIRST) ? (LAST_CNT - bit_count) : bit_count;
  end

  // Word as it stands including the bit sampled at this edge.
  always_comb begin
    word      = sreg;
    word[pos] = in;
  end

  // Framing: in_last must coincide exactly with the final bit of a word.
  always_comb begin
    at_last  = (bit_count == LAST_CNT);
    ferr     = CHECK_LAST && in_valid && (in_last != at_last);
    complete = in_valid && at_last && !ferr;
  end

  // Next bit position: wrap at word end or on a framing violation.
  always_comb begin
    count_next = bit_count;
    if (in_valid) begin
      if (at_last || ferr) count_next = '0;
      else                 count_next = bit_count + 1'b1;
    end
  end

  // Counter, shift register and error pulse; a finished or broken word
  // clears sreg so the next word starts from a clean register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_count <= '0;
      sreg      <= '0;
      frame_err <= 1'b0;
    end else begin
      bit_count <= count_next;
      frame_err <= ferr;
      if (in_valid) sreg <= (at_last || ferr) ? '0 : word;
    end
  end

  assign busy = (bit_count != '0);

  sipo_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .word      (word),
    .load      (complete),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

endmodule
